mem_sched: RTL and testbench
============================

MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 SHALL have parameter TAG_W, default 4: ROB tag width, matching ROB_SIZE_bits+1.
REQ-002 SHALL have parameter DM_DEPTH, default 1024: number of data-memory words; the highest valid address is DM_DEPTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports rq_valid[1:0] (input, 2) and rq_ready[1:0] (output, 2): per-requester handshake; 0 is the load/store buffer, 1 is the debug/loader port.
REQ-006 SHALL have ports rq_we[1:0] (input, 2), rq_base0/rq_base1 (input, 32), rq_imm0/rq_imm1 (input, 32), rq_wdata0/rq_wdata1 (input, 32) and rq_tag0/rq_tag1 (input, TAG_W): request contents.
REQ-007 SHALL have ports dm_addr (output, 10), dm_wdata (output, 32), dm_rd_en (output, 1), dm_wr_en (output, 1), dm_tag (output, TAG_W) and dm_rdata (input, 32): data-memory side.
REQ-008 SHALL have ports rs_valid (output, 1), rs_ready (input, 1), rs_src (output, 1), rs_tag (output, TAG_W), rs_data (output, 32) and rs_invalid (output, 1): response channel.

Function
REQ-009 SHALL implement the FSM states IDLE, ISSUE, CAPT and RESP.
REQ-010 SHALL drive rq_ready to the one-hot grant only while in IDLE; a transfer occurs when rq_valid & rq_ready.
REQ-011 SHALL arbitrate round-robin: when both requesters are valid, grant the one not granted last; last_grant resets to 1, so requester 0 wins first.
REQ-012 SHALL compute the effective address as base+imm with a 33-bit sum; the request is invalid when the sum exceeds DM_DEPTH-1, including on carry-out.
REQ-013 SHALL register on accept: eff[9:0], we, wdata, tag, src and invalid; then IDLE -> ISSUE.
REQ-014 In ISSUE, SHALL assert dm_rd_en=~we or dm_wr_en=we for exactly one cycle, gated low when invalid, with dm_addr/dm_wdata/dm_tag from the registers; then ISSUE -> CAPT.
REQ-015 In CAPT, SHALL capture dm_rdata into rs_data for a valid load, and drive rs_data=0 for stores and invalid accesses; then CAPT -> RESP.
REQ-016 In RESP, SHALL hold rs_valid=1 with stable rs_* until rs_ready; then RESP -> IDLE.
REQ-017 SHALL give a request accepted in cycle N its response rs_valid in cycle N+3 at the earliest; throughput is at most one access per 4 cycles.
REQ-018 SHALL keep rq_ready and both dm enables low outside IDLE and ISSUE respectively, and never assert dm_rd_en and dm_wr_en together.
REQ-019 SHALL ignore a requester deasserting rq_valid without a transfer, with no state change.
REQ-020 SHALL set rs_invalid=1 for an invalid access; the tag is still returned so the ROB can flag an exception.

Reset
REQ-021 On rst low, SHALL asynchronously force state=IDLE, rq_ready=0, dm_rd_en=dm_wr_en=0, rs_valid=0, rs_data=0, rs_tag=0, rs_invalid=0, rs_src=0, dm_addr=0 and last_grant=1.
REQ-022 SHALL abort any in-flight access when reset is asserted mid-operation, with no memory write and no response after release.
REQ-023 SHALL present rq_ready in the first clock after reset release.

Structure
REQ-024 SHALL place the state encoding (2-bit enum) and the DM_DEPTH/address-width constants in the shared memory-unit package.
REQ-025 SHALL use one sub-module, rr_arb2 (2-way round-robin arbiter with grant-pointer register), instantiated once.

Verification
REQ-026 Scenario: req0 load, base=100, imm=4, DM[104]=77, tag=3 -> dm_rd_en pulse with dm_addr=104; rs_valid at N+3 with rs_data=77, rs_tag=3, rs_invalid=0.
REQ-027 Scenario: req1 store, base=1000, imm=24 (sum 1024) -> no dm_wr_en; rs_invalid=1, rs_data=0, rs_src=1.
REQ-028 Scenario: both valid continuously, 4 requests -> grants 0,1,0,1; each rq_ready is a single-cycle pulse.
REQ-029 Scenario: rs_ready held low 5 cycles in RESP -> rs_* stable, rq_ready=0 throughout; IDLE one cycle after rs_ready.
REQ-030 Scenario: base=0xFFFFFFFF, imm=2 (carry-out) -> rs_invalid=1, no memory access.
REQ-031 Scenario: rst asserted during ISSUE of a store to address 5 -> dm_wr_en drops immediately, DM[5] unchanged, no rs_valid after release.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared memory-unit constants and scheduler state encoding
package mem_sched_pkg;

  localparam int DM_DEPTH_DEF = 1024;
  localparam int DM_AW        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_sched_rr_arb2.sv
// rtl/mem_sched_rr_arb2.sv - 2-way round-robin arbiter with a grant-pointer register
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_q, last_grant_d;

  // With no or both requests the grant points away from the last winner,
  // so an idle arbiter already offers the slot to the next requester.
  always_comb begin
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = last_grant_q ? 2'b01 : 2'b10;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) last_grant_d = grant[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= 1'b1;
    else      last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/mem_sched.sv
// rtl/mem_sched.sv - two-requester data-memory scheduler: arbitrate, bounds-check, access, respond
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter int DM_DEPTH = DM_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rq_valid,
  output logic [1:0]       rq_ready,
  input  logic [1:0]       rq_we,
  input  logic [31:0]      rq_base0,
  input  logic [31:0]      rq_base1,
  input  logic [31:0]      rq_imm0,
  input  logic [31:0]      rq_imm1,
  input  logic [31:0]      rq_wdata0,
  input  logic [31:0]      rq_wdata1,
  input  logic [TAG_W-1:0] rq_tag0,
  input  logic [TAG_W-1:0] rq_tag1,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             dm_rd_en,
  output logic             dm_wr_en,
  output logic [TAG_W-1:0] dm_tag,
  input  logic [31:0]      dm_rdata,
  output logic             rs_valid,
  input  logic             rs_ready,
  output logic             rs_src,
  output logic [TAG_W-1:0] rs_tag,
  output logic [31:0]      rs_data,
  output logic             rs_invalid
);

  state_e state_q, state_d;

  logic [1:0]       grant;
  logic             accept;
  logic             sel;
  logic [31:0]      base_sel, imm_sel, wdata_sel;
  logic [TAG_W-1:0] tag_sel;
  logic             we_sel;
  logic [32:0]      sum;
  logic             inv_new;

  logic [DM_AW-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic             inv_q, inv_d;
  logic [31:0]      rs_data_q, rs_data_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rq_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign accept = |(rq_valid & rq_ready);
  assign sel    = grant[1];

  // Sum in 33 bits so a carry out of the 32-bit add also counts as out of range.
  always_comb begin
    base_sel  = sel ? rq_base1  : rq_base0;
    imm_sel   = sel ? rq_imm1   : rq_imm0;
    wdata_sel = sel ? rq_wdata1 : rq_wdata0;
    tag_sel   = sel ? rq_tag1   : rq_tag0;
    we_sel    = rq_we[sel];
    sum       = {1'b0, base_sel} + {1'b0, imm_sel};
    inv_new   = sum > 33'(DM_DEPTH - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (rs_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst gates rq_ready so no grant is offered while reset is held.
  always_comb begin
    rq_ready = (state_q == IDLE && rst) ? grant : 2'b00;
    dm_rd_en = (state_q == ISSUE) && !we_q && !inv_q;
    dm_wr_en = (state_q == ISSUE) &&  we_q && !inv_q;
    rs_valid = (state_q == RESP);
  end

  always_comb begin
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    tag_d     = tag_q;
    src_d     = src_q;
    inv_d     = inv_q;
    rs_data_d = rs_data_q;
    if (accept) begin
      addr_d  = sum[DM_AW-1:0];
      we_d    = we_sel;
      wdata_d = wdata_sel;
      tag_d   = tag_sel;
      src_d   = sel;
      inv_d   = inv_new;
    end
    if (state_q == CAPT) rs_data_d = (!we_q && !inv_q) ? dm_rdata : 32'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      tag_q     <= '0;
      src_q     <= 1'b0;
      inv_q     <= 1'b0;
      rs_data_q <= '0;
    end else begin
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      tag_q     <= tag_d;
      src_q     <= src_d;
      inv_q     <= inv_d;
      rs_data_q <= rs_data_d;
    end
  end

  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign dm_tag     = tag_q;
  assign rs_src     = src_q;
  assign rs_tag     = tag_q;
  assign rs_invalid = inv_q;
  assign rs_data    = rs_data_q;

endmodule

// File: tb/tb_mem_sched.sv
// tb/tb_mem_sched.sv - scoreboard bench for mem_sched with a synchronous data-memory model
module tb_mem_sched;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       rq_valid = 2'b00;
  logic [1:0]       rq_ready;
  logic [1:0]       rq_we = 2'b00;
  logic [31:0]      rq_base0 = '0, rq_base1 = '0, rq_imm0 = '0, rq_imm1 = '0;
  logic [31:0]      rq_wdata0 = '0, rq_wdata1 = '0;
  logic [TAG_W-1:0] rq_tag0 = '0, rq_tag1 = '0;
  logic [9:0]       dm_addr;
  logic [31:0]      dm_wdata;
  logic             dm_rd_en, dm_wr_en;
  logic [TAG_W-1:0] dm_tag;
  logic [31:0]      dm_rdata;
  logic             rs_valid;
  logic             rs_ready = 1'b1;
  logic             rs_src;
  logic [TAG_W-1:0] rs_tag;
  logic [31:0]      rs_data;
  logic             rs_invalid;

  always #5 clk = ~clk;

  mem_sched #(.TAG_W(TAG_W), .DM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we),
    .rq_base0(rq_base0), .rq_base1(rq_base1), .rq_imm0(rq_imm0), .rq_imm1(rq_imm1),
    .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1), .rq_tag0(rq_tag0), .rq_tag1(rq_tag1),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en),
    .dm_tag(dm_tag), .dm_rdata(dm_rdata),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_src(rs_src), .rs_tag(rs_tag),
    .rs_data(rs_data), .rs_invalid(rs_invalid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int a);
    case (a)
      5:       return 32'h55;
      50:      return 32'h99;
      104:     return 32'd77;
      200:     return 32'd11;
      1023:    return 32'hCAFE;
      default: return 32'(a);
    endcase
  endfunction

  logic [31:0] mem [1024];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (dm_rd_en) dm_rdata <= mem[dm_addr];
      if (dm_wr_en) mem[dm_addr] <= dm_wdata;
    end
  end

  typedef struct {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             inv;
    int               cyc;
  } rs_exp_t;

  typedef struct {
    logic             wr;
    logic [9:0]       addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag;
  } dm_exp_t;

  rs_exp_t rs_q[$];
  dm_exp_t dm_q[$];
  rs_exp_t rs_e;
  dm_exp_t dm_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic rs_valid_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (dm_rd_en || dm_wr_en) begin
        check("dm enables exclusive", 64'(dm_rd_en & dm_wr_en), 64'd0);
        if (dm_q.size() == 0) check("dm unexpected access", 64'd1, 64'd0);
        else begin
          dm_e = dm_q.pop_front();
          check("dm_wr_en", 64'(dm_wr_en), 64'(dm_e.wr));
          check("dm_addr", 64'(dm_addr), 64'(dm_e.addr));
          check("dm_tag", 64'(dm_tag), 64'(dm_e.tag));
          if (dm_e.wr) check("dm_wdata", 64'(dm_wdata), 64'(dm_e.wdata));
        end
      end
      if (rs_valid && !rs_valid_prev) begin
        if (rs_q.size() == 0) check("rs unexpected valid", 64'd1, 64'd0);
        else check("rs latency", 64'(cyc), 64'(rs_q[0].cyc + 3));
      end
      if (rs_valid && rs_ready && rs_q.size() != 0) begin
        rs_e = rs_q.pop_front();
        check("rs_src", 64'(rs_src), 64'(rs_e.src));
        check("rs_tag", 64'(rs_tag), 64'(rs_e.tag));
        check("rs_data", 64'(rs_data), 64'(rs_e.data));
        check("rs_invalid", 64'(rs_invalid), 64'(rs_e.inv));
      end
    end
    rs_valid_prev <= rs_valid;
  end

  task automatic issue(input int s, input logic we, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] wdata, input logic [TAG_W-1:0] tag,
                       input logic [31:0] exp_data, input logic exp_inv, input logic exp_resp);
    int n;
    @(posedge clk);
    #1;
    if (s == 0) begin
      rq_we[0] = we; rq_base0 = base; rq_imm0 = imm; rq_wdata0 = wdata; rq_tag0 = tag;
    end else begin
      rq_we[1] = we; rq_base1 = base; rq_imm1 = imm; rq_wdata1 = wdata; rq_tag1 = tag;
    end
    rq_valid[s] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rq_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("accept timeout", 64'd1, 64'd0);
      rq_valid[s] = 1'b0;
    end else begin
      if (exp_resp) rs_q.push_back('{1'(s), tag, exp_data, exp_inv, cyc});
      if (!exp_inv) dm_q.push_back('{we, 10'(base + imm), wdata, tag});
      @(posedge clk);
      #1;
      rq_valid[s] = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((rs_q.size() != 0 || dm_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [1:0] exp_g [4];
    int n;
    int seen;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

    repeat (3) @(negedge clk);
    check("reset rq_ready", 64'(rq_ready), 64'd0);
    check("reset rs_valid", 64'(rs_valid), 64'd0);
    check("reset dm_rd_en", 64'(dm_rd_en), 64'd0);
    check("reset dm_wr_en", 64'(dm_wr_en), 64'd0);
    check("reset dm_addr", 64'(dm_addr), 64'd0);
    check("reset rs_data", 64'(rs_data), 64'd0);
    check("reset rs_tag", 64'(rs_tag), 64'd0);
    check("reset rs_invalid", 64'(rs_invalid), 64'd0);
    check("reset rs_src", 64'(rs_src), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rq_ready after release", 64'(rq_ready), 64'(2'b01));

    // load 100+4 -> DM[104]=77
    issue(0, 1'b0, 32'd100, 32'd4, 32'd0, 4'd3, 32'd77, 1'b0, 1'b1);
    // store at sum 1024: out of range, no write
    issue(1, 1'b1, 32'd1000, 32'd24, 32'h1234, 4'd5, 32'd0, 1'b1, 1'b1);
    wait_drain();

    // both requesters valid continuously: 0,1,0,1
    @(posedge clk);
    #1;
    rq_we = 2'b10;
    rq_base0 = 32'd200; rq_imm0 = 32'd0; rq_tag0 = 4'd1;
    rq_base1 = 32'd300; rq_imm1 = 32'd5; rq_wdata1 = 32'hAB; rq_tag1 = 4'd2;
    rq_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (rq_ready == 2'b00 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("rr grant", 64'(rq_ready), 64'(exp_g[k]));
      if (k % 2 == 0) begin
        rs_q.push_back('{1'b0, 4'd1, 32'd11, 1'b0, cyc});
        dm_q.push_back('{1'b0, 10'd200, 32'd0, 4'd1});
      end else begin
        rs_q.push_back('{1'b1, 4'd2, 32'd0, 1'b0, cyc});
        dm_q.push_back('{1'b1, 10'd305, 32'hAB, 4'd2});
      end
      @(posedge clk);
      #1;
      if (k == 3) rq_valid = 2'b00;
      @(negedge clk);
      check("rq_ready single pulse", 64'(rq_ready), 64'd0);
    end
    wait_drain();

    // response back-pressure
    rs_ready = 1'b0;
    issue(0, 1'b0, 32'd50, 32'd0, 32'd0, 4'd7, 32'h99, 1'b0, 1'b1);
    n = 0;
    while (!rs_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rs_valid under stall", 64'(rs_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall rs_valid", 64'(rs_valid), 64'd1);
      check("stall rs_data", 64'(rs_data), 64'h99);
      check("stall rs_tag", 64'(rs_tag), 64'd7);
      check("stall rq_ready", 64'(rq_ready), 64'd0);
    end
    @(posedge clk);
    #1 rs_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle after rs_ready", 64'(rq_ready), 64'(2'b10));
    check("rs_valid dropped", 64'(rs_valid), 64'd0);

    // carry-out of base+imm
    issue(0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd9, 32'd0, 1'b1, 1'b1);
    // highest valid address, then read back the earlier store
    issue(1, 1'b0, 32'd1000, 32'd23, 32'd0, 4'd4, 32'hCAFE, 1'b0, 1'b1);
    issue(0, 1'b0, 32'd300, 32'd5, 32'd0, 4'd8, 32'hAB, 1'b0, 1'b1);
    wait_drain();

    // reset during ISSUE of a store to address 5
    issue(0, 1'b1, 32'd5, 32'd0, 32'hDEAD, 4'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("store in ISSUE", 64'(dm_wr_en), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("wr_en drops on reset", 64'(dm_wr_en), 64'd0);
    check("rs_valid in reset", 64'(rs_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rq_ready after mid-op reset", 64'(rq_ready), 64'(2'b01));
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rs_valid) seen++;
    end
    check("no response after reset", 64'(seen), 64'd0);
    check("DM[5] unchanged", 64'(mem[5]), 64'h55);

    issue(1, 1'b0, 32'd100, 32'd4, 32'd0, 4'd6, 32'd77, 1'b0, 1'b1);
    wait_drain();
    check("rs queue empty", 64'(rs_q.size()), 64'd0);
    check("dm queue empty", 64'(dm_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
